miim_master: RTL and testbench

MIIM_MASTER -- requirements
Module: miim_master

---
 rtl/miim_master.sv | 113 +++++++++++
 tb/tb_miim_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/miim_master.sv
// MDIO management-frame master: 64-bit frames (preamble, header, turnaround, data) with an
// MDC of 2*CLK_DIV clk_i cycles per bit; read data is shifted in MSB first from mdio_i.
module miim_master #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        start_i,
  input  logic        op_read_i,
  input  logic [4:0]  phy_addr_i,
  input  logic [4:0]  reg_addr_i,
  input  logic [15:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StPreamble, StHeader, StTa, StData, StDone} state_e;

  state_e         state_q;
  logic [DivW-1:0] div_q;
  logic [5:0]     bit_q;
  logic           op_read_q;
  logic [31:0]    tx_q;
  logic [15:0]    rx_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      op_read_q <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rdata_o   <= 16'h0000;
      mdc_o     <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q   <= StPreamble;
            busy_o    <= 1'b1;
            op_read_q <= op_read_i;
            // Everything after the preamble: ST, OP, PHYAD, REGAD, TA, DATA
            tx_q      <= {2'b01, (op_read_i ? 2'b10 : 2'b01), phy_addr_i, reg_addr_i, 2'b10,
                          wdata_i};
            div_q     <= '0;
            bit_q     <= '0;
            mdc_o     <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe_o <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_o  <= 1'b0;
        end
        default: begin
          // Capture read data in the first cycle MDC is high
          if (state_q == StData && mdc_o && div_q == '0) begin
            rx_q <= {rx_q[14:0], mdio_i};
          end
          if (div_q == DivLast) begin
            div_q <= '0;
            if (!mdc_o) begin
              mdc_o <= 1'b1;
            end else begin
              mdc_o <= 1'b0;
              if (bit_q == 6'd63) begin
                state_q   <= StDone;
                done_o    <= 1'b1;
                mdio_o    <= 1'b1;
                mdio_oe_o <= 1'b0;
                if (op_read_q) begin
                  rdata_o <= rx_q;
                end
              end else begin
                bit_q <= bit_q + 6'd1;
                if (bit_q >= 6'd31) begin
                  mdio_o <= tx_q[31];
                  tx_q   <= {tx_q[30:0], 1'b0};
                end
                // Release the line to the PHY from the turnaround onward
                if (op_read_q && bit_q >= 6'd45) begin
                  mdio_oe_o <= 1'b0;
                  mdio_o    <= 1'b1;
                end
                if (bit_q == 6'd31) state_q <= StHeader;
                if (bit_q == 6'd45) state_q <= StTa;
                if (bit_q == 6'd47) state_q <= StData;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miim_master.sv
// Bench for miim_master: two instances (CLK_DIV 10 and 2), a scoreboard of expected frames,
// a PHY read model and per-cycle MDC/busy/done checks.
module tb_miim_master;

  logic clk = 1'b0;
  logic resetn;
  logic start [2];
  logic op_read [2];
  logic busy [2];
  logic done [2];
  logic mdc [2];
  logic mdio [2];
  logic mdio_oe [2];
  logic mdio_in [2];
  logic [4:0] phy [2];
  logic [4:0] rega [2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];
  logic [15:0] last_rd [2];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] bits;
    logic [63:0] oe;
    logic [15:0] rdata;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  miim_master #(.CLK_DIV(10)) dut (
    .clk_i(clk), .resetn_i(resetn), .start_i(start[0]), .op_read_i(op_read[0]),
    .phy_addr_i(phy[0]), .reg_addr_i(rega[0]), .wdata_i(wdata[0]), .busy_o(busy[0]),
    .done_o(done[0]), .rdata_o(rdata[0]), .mdc_o(mdc[0]), .mdio_o(mdio[0]),
    .mdio_oe_o(mdio_oe[0]), .mdio_i(mdio_in[0])
  );

  miim_master #(.CLK_DIV(2)) dut2 (
    .clk_i(clk), .resetn_i(resetn), .start_i(start[1]), .op_read_i(op_read[1]),
    .phy_addr_i(phy[1]), .reg_addr_i(rega[1]), .wdata_i(wdata[1]), .busy_o(busy[1]),
    .done_o(done[1]), .rdata_o(rdata[1]), .mdc_o(mdc[1]), .mdio_o(mdio[1]),
    .mdio_oe_o(mdio_oe[1]), .mdio_i(mdio_in[1])
  );

  // Runs one frame on unit u; inj_bit >= 0 pulses a stray start_i during that bit.
  task automatic run_frame(input int u, input int d, input logic op, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd, input logic [15:0] pd,
                           input int inj_bit);
    exp_t e;
    exp_t x;
    logic [63:0] ob;
    logic [63:0] oo;
    logic prev_mdc;
    logic exp_mdc;
    logic [15:0] rd_obs;
    int cyc, nbits, done_cyc, mdc_err, busy_err, done_err, bi, inj_cyc;
    e.bits = {32'hFFFF_FFFF, 2'b01, (op ? 2'b10 : 2'b01), pa, ra, 2'b10, (op ? 16'h0000 : wd)};
    e.oe = op ? {{46{1'b1}}, {18{1'b0}}} : {64{1'b1}};
    if (op) last_rd[u] = pd;
    e.rdata = last_rd[u];
    e.done_cyc = 128 * d + 1;
    sb.push_back(e);

    @(posedge clk); #1;
    op_read[u] = op; phy[u] = pa; rega[u] = ra; wdata[u] = wd; start[u] = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy[u] !== 1'b0 || done[u] !== 1'b0 || mdc[u] !== 1'b0 || mdio_oe[u] !== 1'b0 ||
        mdio[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_outputs u=%0d: busy=%b done=%b mdc=%b oe=%b mdio=%b, required 0 0 0 0 1",
               u, busy[u], done[u], mdc[u], mdio_oe[u], mdio[u]);
    end
    @(posedge clk); #1;
    // Inputs change after accept; the frame must use the latched copies
    start[u] = 1'b0; op_read[u] = ~op; phy[u] = ~pa; rega[u] = ~ra; wdata[u] = ~wd;

    ob = '0; oo = '0; nbits = 0; done_cyc = -1; mdc_err = 0; busy_err = 0; done_err = 0;
    prev_mdc = 1'b0; rd_obs = 16'hxxxx; cyc = 1;
    inj_cyc = (inj_bit >= 0) ? 1 + 2 * d * inj_bit + 1 : -1;
    while (done_cyc < 0 && cyc <= 128 * d + 16) begin
      @(negedge clk);
      if (cyc <= 128 * d + 1) begin
        exp_mdc = (((cyc - 1) % (2 * d)) >= d);
        if (mdc[u] !== exp_mdc) mdc_err++;
        if (busy[u] !== 1'b1) busy_err++;
      end
      if (cyc <= 128 * d && done[u] !== 1'b0) done_err++;
      if (mdc[u] === 1'b1 && prev_mdc === 1'b0 && nbits < 64) begin
        ob[63 - nbits] = mdio[u];
        oo[63 - nbits] = mdio_oe[u];
        nbits++;
      end
      prev_mdc = mdc[u];
      if (done[u] === 1'b1) begin
        done_cyc = cyc;
        rd_obs = rdata[u];
      end
      bi = cyc / (2 * d);
      mdio_in[u] = (op && bi >= 48 && bi <= 63) ? pd[15 - (bi - 48)] : 1'b1;
      if (cyc == inj_cyc) begin
        start[u] = 1'b1; phy[u] = pa ^ 5'h15; rega[u] = ra ^ 5'h0A; op_read[u] = ~op;
      end else begin
        start[u] = 1'b0;
      end
      cyc++;
    end
    mdio_in[u] = 1'b1;

    x = sb.pop_front();
    n_chk++;
    if (nbits !== 64) begin
      n_fail++; $display("FAIL bit_count u=%0d: got %0d, required 64", u, nbits);
    end
    n_chk++;
    if ((ob & x.oe) !== (x.bits & x.oe)) begin
      n_fail++; $display("FAIL bitstream u=%0d: got %h, required %h", u, ob & x.oe, x.bits & x.oe);
    end
    n_chk++;
    if (oo !== x.oe) begin
      n_fail++; $display("FAIL mdio_oe u=%0d: got %h, required %h", u, oo, x.oe);
    end
    n_chk++;
    if (done_cyc !== x.done_cyc) begin
      n_fail++; $display("FAIL done_cycle u=%0d: got %0d, required %0d", u, done_cyc, x.done_cyc);
    end
    n_chk++;
    if (mdc_err !== 0) begin
      n_fail++; $display("FAIL mdc_phase u=%0d: %0d wrong cycles, required 0", u, mdc_err);
    end
    n_chk++;
    if (busy_err !== 0) begin
      n_fail++; $display("FAIL busy u=%0d: %0d wrong cycles, required 0", u, busy_err);
    end
    n_chk++;
    if (done_err !== 0) begin
      n_fail++; $display("FAIL early_done u=%0d: %0d cycles, required 0", u, done_err);
    end
    n_chk++;
    if (rd_obs !== x.rdata) begin
      n_fail++; $display("FAIL rdata u=%0d: got %h, required %h", u, rd_obs, x.rdata);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      @(negedge clk);
      n_chk++;
      if (busy[u] !== 1'b0 || done[u] !== 1'b0 || mdc[u] !== 1'b0 || mdio[u] !== 1'b1 ||
          mdio_oe[u] !== 1'b0 || rdata[u] !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_values u=%0d: busy=%b done=%b mdc=%b mdio=%b oe=%b rdata=%h, required 0 0 0 1 0 0000",
                 u, busy[u], done[u], mdc[u], mdio[u], mdio_oe[u], rdata[u]);
      end
    end
    // Start present as reset releases must be taken on the first edge
    @(negedge clk);
    op_read[0] = 1'b0; phy[0] = 5'h02; rega[0] = 5'h03; wdata[0] = 16'h1234; start[0] = 1'b1;
    resetn = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy[0] !== 1'b1 || mdio_oe[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL first_edge_accept: busy=%b oe=%b, required 1 1", busy[0], mdio_oe[0]);
    end
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    last_rd[0] = 16'h0000; last_rd[1] = 16'h0000;
  endtask

  task automatic test_write();
    run_frame(0, 10, 1'b0, 5'h01, 5'h00, 16'h1140, 16'h0000, -1);
  endtask

  task automatic test_read();
    run_frame(0, 10, 1'b1, 5'h1F, 5'h01, 16'hFFFF, 16'h796D, -1);
    // A following write must leave rdata_o at the read value
    run_frame(0, 10, 1'b0, 5'h0A, 5'h11, 16'hBEEF, 16'h0000, -1);
  endtask

  task automatic test_ignore_start();
    run_frame(0, 10, 1'b0, 5'h07, 5'h1C, 16'h5AC3, 16'h0000, 20);
  endtask

  task automatic test_reset_mid();
    int done_seen;
    @(posedge clk); #1;
    op_read[0] = 1'b1; phy[0] = 5'h03; rega[0] = 5'h04; wdata[0] = 16'hA5A5; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (20 * 50 + 5) @(negedge clk);
    n_chk++;
    if (busy[0] !== 1'b1 || mdio_oe[0] !== 1'b0) begin
      n_fail++; $display("FAIL mid_frame_state: busy=%b oe=%b, required 1 0", busy[0], mdio_oe[0]);
    end
    #2 resetn = 1'b0;
    #1;
    n_chk++;
    if (mdc[0] !== 1'b0 || mdio_oe[0] !== 1'b0 || busy[0] !== 1'b0 || mdio[0] !== 1'b1 ||
        rdata[0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: mdc=%b oe=%b busy=%b mdio=%b rdata=%h, required 0 0 0 1 0000",
               mdc[0], mdio_oe[0], busy[0], mdio[0], rdata[0]);
    end
    last_rd[0] = 16'h0000;
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done[0] !== 1'b0) done_seen++;
    end
    resetn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) done_seen++;
    end
    n_chk++;
    if (done_seen !== 0) begin
      n_fail++; $display("FAIL aborted_frame: %0d done/busy cycles, required 0", done_seen);
    end
    run_frame(0, 10, 1'b0, 5'h12, 5'h05, 16'h0F0F, 16'h0000, -1);
  endtask

  task automatic test_back_to_back();
    run_frame(1, 2, 1'b1, 5'h11, 5'h02, 16'h0000, 16'hC3A1, -1);
    run_frame(1, 2, 1'b0, 5'h06, 5'h1E, 16'h8001, 16'h0000, -1);
    run_frame(1, 2, 1'b1, 5'h00, 5'h1F, 16'h0000, 16'h1E5B, -1);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; op_read[u] = 1'b0; phy[u] = '0; rega[u] = '0; wdata[u] = '0;
      mdio_in[u] = 1'b1; last_rd[u] = 16'h0000;
    end
    test_reset();
    test_write();
    test_read();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
